// File: rtl/rom_burst_reader_pkg.sv
`default_nettype none
// =============================================================================
// rom_burst_reader_pkg : shared state encoding and default sizing for the reader
// Rev 1.0
// =============================================================================
package rom_burst_reader_pkg;

  localparam int unsigned C_ADDR_W = 5;
  localparam int unsigned C_DATA_W = 8;
  localparam int unsigned C_DEPTH  = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_burst_addr_gen.sv
`default_nettype none
// =============================================================================
// rom_burst_addr_gen : loadable address incrementer with remaining-word counter
// Rev 1.0
// =============================================================================
module rom_burst_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] count_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
      rem_q  <= count_i;
    end else if (en_i) begin
      addr_q <= addr_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end
  end

  assign addr_o = addr_q;
  // The word being captured now is the final one of the burst.
  assign last_o = (rem_q == ADDR_W'(1));

endmodule
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// =============================================================================
// rom_burst_reader : burst read sequencer for the ROM with registered stream out
// Optional burst checksum enabled by defining ROM_BURST_CHKSUM_EN.  Rev 1.0
// =============================================================================
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int DEPTH  = C_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              rom_cs,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] chksum
);

  state_t            state_q, state_d;
  logic              accept_d, reject_d, capture_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_w;
  logic              last_w;
  logic [ADDR_W:0]   end_w;
  logic              range_err_w;

  // One extra bit so base+count can never wrap past the ROM end.
  assign end_w       = {1'b0, base_addr} + {1'b0, count};
  assign range_err_w = (end_w > (ADDR_W+1)'(DEPTH));

  rom_burst_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept_d),
    .en_i    (capture_d),
    .base_i  (base_addr),
    .count_i (count),
    .addr_o  (addr_w),
    .last_o  (last_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept_d  = 1'b0;
    reject_d  = 1'b0;
    capture_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_err_w) begin
            reject_d = 1'b1;
          end else begin
            accept_d = 1'b1;
            state_d  = (count == '0) ? S_FIN : S_READ;
          end
        end
      end
      S_READ: begin
        if (!out_valid_q || out_ready) begin
          capture_d = 1'b1;
          if (last_w) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= reject_d;
      if (capture_d) begin
        out_data_q  <= rom_data;
        out_valid_q <= 1'b1;
      end else if ((state_q == S_DRAIN) && out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ROM_BURST_CHKSUM_EN
  logic [DATA_W-1:0] chksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chksum_q <= '0;
    end else if (accept_d) begin
      chksum_q <= '0;
    end else if (capture_d) begin
      chksum_q <= chksum_q + rom_data;
    end
  end

  assign chksum = chksum_q;
`else
  assign chksum = '0;
`endif

  assign rom_cs    = (state_q == S_READ);
  assign rom_rd_en = (state_q == S_READ);
  assign rom_addr  = rom_cs ? addr_w : '0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// =============================================================================
// tb_rom_burst_reader : directed and random scoreboard bench for rom_burst_reader
// Rev 1.0
// =============================================================================
module tb_rom_burst_reader;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 24;
`ifdef ROM_BURST_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] count = '0;
  logic          out_ready = 1'b0;
  logic          rom_cs, rom_rd_en, out_valid, busy, done, err;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, out_data, chksum;

  logic [DW-1:0] rom [0:31];
  assign rom_data = rom[rom_addr];

  rom_burst_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rom_cs    (rom_cs),
    .rom_rd_en (rom_rd_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .chksum    (chksum)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] beat_q[$];
  logic [DW-1:0] done_q[$];
  int            exp_err = 0;
  bit            rand_ready = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a request either errors or yields rom[b..b+c-1] and one done.
  task automatic issue(input int b, input int c);
    int sum;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    count     = AW'(c);
    if (b + c > DEPTH) begin
      exp_err++;
    end else begin
      sum = 0;
      for (int i = 0; i < c; i++) begin
        beat_q.push_back(rom[b+i]);
        sum += rom[b+i];
      end
      done_q.push_back(CHK_EN ? DW'(sum % 256) : '0);
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      step();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (rst) begin
      beat_q.delete();
      done_q.delete();
      exp_err    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0d expected no beat", out_data);
        end else begin
          chk("beat", 32'(out_data), 32'(beat_q.pop_front()));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done 1 expected 0");
        end else begin
          chk("done_chksum", 32'(chksum), 32'(done_q.pop_front()));
          chk("beats_left_at_done", 32'(beat_q.size()), 32'd0);
          chk("valid_at_done", 32'(out_valid), 32'd0);
        end
      end
      if (err) begin
        if (exp_err == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got err 1 expected 0");
        end else begin
          exp_err--;
          chk("err_busy", 32'(busy), 32'd0);
        end
      end
      if ((rom_cs || rom_rd_en) && !busy) begin
        checks++;
        errors++;
        $display("FAIL rom_access_idle: got rom_cs %0d rd_en %0d expected 0", rom_cs, rom_rd_en);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c;
    for (int i = 0; i < 32; i++) rom[i] = DW'($urandom);
    rom[0]  = 8'd21;  rom[1]  = 8'd255; rom[2]  = 8'd33;
    rom[7]  = 8'd88;  rom[8]  = 8'd28;
    rom[16] = 8'd128; rom[17] = 8'd138;
    rom[22] = 8'd188; rom[23] = 8'd198;

    repeat (3) step();
    chk("reset_outputs", {out_valid, done, busy, err, rom_cs, rom_rd_en, rom_addr, out_data, chksum}, 32'd0);
    rst = 1'b0;

    // Basic burst: latency, throughput, done placement, checksum.
    out_ready = 1'b1;
    issue(0, 3);
    chk("t1_cs_n1", 32'(rom_cs), 32'd1);
    chk("t1_addr_n1", 32'(rom_addr), 32'd0);
    chk("t1_valid_n1", 32'(out_valid), 32'd0);
    step();
    chk("t1_data_n2", 32'(out_data), 32'd21);
    chk("t1_valid_n2", 32'(out_valid), 32'd1);
    step();
    chk("t1_data_n3", 32'(out_data), 32'd255);
    step();
    chk("t1_data_n4", 32'(out_data), 32'd33);
    chk("t1_done_n4", 32'(done), 32'd0);
    step();
    chk("t1_done_n5", 32'(done), 32'd1);
    chk("t1_chksum", 32'(chksum), CHK_EN ? 32'd53 : 32'd0);
    step();
    chk("t1_done_n6", 32'(done), 32'd0);
    chk("t1_busy_n6", 32'(busy), 32'd0);

    // Boundary-crossing burst.
    issue(7, 2);
    chk("t2_addr_n1", 32'(rom_addr), 32'd7);
    step();
    chk("t2_addr_n2", 32'(rom_addr), 32'd8);
    chk("t2_data_n2", 32'(out_data), 32'd88);
    step();
    chk("t2_data_n3", 32'(out_data), 32'd28);
    chk("t2_cs_n3", 32'(rom_cs), 32'd0);
    wait_idle();

    // Backpressure: consumer stalls three cycles after the first beat.
    out_ready = 1'b0;
    issue(16, 2);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_hold_data", 32'(out_data), 32'd128);
      chk("t3_hold_addr", 32'(rom_addr), 32'd17);
      chk("t3_hold_cs", 32'(rom_cs), 32'd1);
    end
    step();
    out_ready = 1'b1;
    step();
    chk("t3_second_data", 32'(out_data), 32'd138);
    chk("t3_second_valid", 32'(out_valid), 32'd1);
    step();
    chk("t3_done", 32'(done), 32'd1);
    wait_idle();

    // Range error: no ROM access, no busy.
    issue(22, 3);
    chk("t4_err_n1", 32'(err), 32'd1);
    chk("t4_busy_n1", {busy, rom_cs, out_valid}, 32'd0);
    step();
    chk("t4_err_n2", 32'(err), 32'd0);
    chk("t4_busy_n2", {busy, rom_cs, out_valid}, 32'd0);

    // Zero-length burst.
    issue(5, 0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_no_access", {rom_cs, out_valid}, 32'd0);
    step();
    chk("t5_done_after", {done, busy}, 32'd0);

    // Reset in the middle of a burst.
    issue(0, 8);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_outputs", {out_valid, done, busy, err, rom_cs, rom_rd_en, rom_addr, out_data, chksum}, 32'd0);
    rst = 1'b0;
    issue(23, 1);
    step();
    chk("t6_after_rst_data", 32'(out_data), 32'd198);
    wait_idle();

    // Random bursts with random backpressure and ignored starts while busy.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b = $urandom_range(0, 31);
      c = $urandom_range(0, 12);
      issue(b, c);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 2)) step();
        if (busy) begin
          start     = 1'b1;
          base_addr = AW'($urandom);
          count     = AW'($urandom);
          step();
          start = 1'b0;
        end
      end
      wait_idle();
    end
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    repeat (5) step();
    chk("end_beats_pending", 32'(beat_q.size()), 32'd0);
    chk("end_done_pending", 32'(done_q.size()), 32'd0);
    chk("end_err_pending", 32'(exp_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
